// File: rtl/reg_sequencer_pkg.sv
// Shared encodings for the register-transfer sequencer: instruction modes,
// save-bus sources, register indices and FSM states.
package reg_sequencer_pkg;

    typedef enum logic [1:0] {
        MODE_IMM  = 2'b00,
        MODE_ALU  = 2'b01,
        MODE_COPY = 2'b10,
        MODE_COND = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        BUS_IMM  = 2'd0,
        BUS_ALU  = 2'd1,
        BUS_COPY = 2'd2
    } bus_sel_e;

    localparam logic [2:0] R0  = 3'd0;
    localparam logic [2:0] R1  = 3'd1;
    localparam logic [2:0] R2  = 3'd2;
    localparam logic [2:0] R3  = 3'd3;
    localparam logic [2:0] R4  = 3'd4;
    localparam logic [2:0] R5  = 3'd5;
    localparam logic [2:0] IN  = 3'd6;
    localparam logic [2:0] OUT = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2
    } state_e;

endpackage

// File: rtl/reg_sequencer_idx_to_onehot.sv
// 3-bit register index to 8-bit one-hot enable vector.
module idx_to_onehot (
    input  logic [2:0] idx_i,
    output logic [7:0] onehot_o
);

    assign onehot_o = 8'b0000_0001 << idx_i;

endmodule

// File: rtl/reg_sequencer.sv
// Three-state instruction sequencer: latches an instruction, decodes it into
// registered one-hot register enables for one EXEC cycle, then advances pc.
module reg_sequencer
    import reg_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       res,
    input  logic [7:0] instr,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic       cond_true,
    input  logic [7:0] branch_target,
    output logic [7:0] load1_en,
    output logic [7:0] load2_en,
    output logic [7:0] save_en,
    output logic [1:0] bus_sel,
    output logic [7:0] imm_out,
    output logic [2:0] alu_op,
    output logic [7:0] pc,
    output logic       busy
);

    state_e     state_q, state_d;
    logic [7:0] instr_q, instr_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] load1_en_q, load1_en_d;
    logic [7:0] load2_en_q, load2_en_d;
    logic [7:0] save_en_q, save_en_d;
    logic [1:0] bus_sel_q, bus_sel_d;
    logic [7:0] imm_q, imm_d;
    logic [2:0] alu_q, alu_d;

    mode_e      mode;
    logic [2:0] l1_idx, sv_idx;
    logic [7:0] l1_oh, sv_oh;

    assign mode = mode_e'(instr_q[7:6]);

    always_comb begin
        l1_idx = R0;
        sv_idx = R0;
        case (mode)
            MODE_ALU: begin
                l1_idx = R1;
                sv_idx = R3;
            end
            MODE_COPY: begin
                l1_idx = instr_q[5:3];
                sv_idx = instr_q[2:0];
            end
            default: ;
        endcase
    end

    idx_to_onehot u_load1_dec (.idx_i(l1_idx), .onehot_o(l1_oh));
    idx_to_onehot u_save_dec  (.idx_i(sv_idx), .onehot_o(sv_oh));

    // Enables are computed in DECODE and registered, so they are nonzero only in EXEC.
    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        load1_en_d = 8'h00;
        load2_en_d = 8'h00;
        save_en_d  = 8'h00;
        bus_sel_d  = bus_sel_q;
        imm_d      = imm_q;
        alu_d      = alu_q;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXEC;
                case (mode)
                    MODE_IMM: begin
                        imm_d     = {2'b00, instr_q[5:0]};
                        save_en_d = sv_oh;
                        bus_sel_d = BUS_IMM;
                    end
                    MODE_ALU: begin
                        alu_d      = instr_q[2:0];
                        load1_en_d = l1_oh;
                        load2_en_d = 8'b0000_0001 << R2;
                        save_en_d  = sv_oh;
                        bus_sel_d  = BUS_ALU;
                    end
                    MODE_COPY: begin
                        load1_en_d = l1_oh;
                        save_en_d  = sv_oh;
                        bus_sel_d  = BUS_COPY;
                    end
                    MODE_COND: begin
                        alu_d = instr_q[2:0];
                    end
                    default: ;
                endcase
            end
            ST_EXEC: begin
                state_d = ST_IDLE;
                pc_d    = (mode == MODE_COND && cond_true) ? branch_target : pc_q + 8'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q    <= ST_IDLE;
            pc_q       <= 8'h00;
            load1_en_q <= 8'h00;
            load2_en_q <= 8'h00;
            save_en_q  <= 8'h00;
            bus_sel_q  <= 2'd0;
            imm_q      <= 8'h00;
            alu_q      <= 3'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            load1_en_q <= load1_en_d;
            load2_en_q <= load2_en_d;
            save_en_q  <= save_en_d;
            bus_sel_q  <= bus_sel_d;
            imm_q      <= imm_d;
            alu_q      <= alu_d;
        end
    end

    // Instruction latch is pure data; only its capture is gated by the FSM.
    always_ff @(posedge clk) begin
        instr_q <= instr_d;
    end

    assign instr_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign load1_en    = load1_en_q;
    assign load2_en    = load2_en_q;
    assign save_en     = save_en_q;
    assign bus_sel     = bus_sel_q;
    assign imm_out     = imm_q;
    assign alu_op      = alu_q;
    assign pc          = pc_q;

endmodule
